// File: rtl/shift_reg_sequencer_pkg.sv
// Shared definitions for the shift register sequencer: FSM encoding and the
// rule that maps a requested frame length onto the register size.
package shift_reg_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A length of zero or one longer than the register means a full-width frame.
  function automatic int unsigned eff_len(input int unsigned length,
                                          input int unsigned width);
    return (length == 0 || length > width) ? width : length;
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit shift register: sync clear, parallel load, and MSB-first shift
// with the serial input entering at the LSB.
module shift_reg_core
  import shift_reg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_en_i,
  input  logic             shift_in_i,
  output logic             msb_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Clear beats load, load beats shift.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_en_i) begin
      data_d = {data_q[WIDTH-2:0], shift_in_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o  = data_q[WIDTH-1];
  assign data_o = data_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Frame sequencer: accepts a parallel word, shifts a programmable number of
// bits out MSB-first while capturing the serial input, then presents the word.
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  output logic             Ready,
  input  logic [WIDTH-1:0] Load_data,
  input  logic [CNT_W-1:0] Length,
  input  logic             Shift_in,
  output logic             Shift_out,
  output logic             Shift_en,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Capture_data,
  output logic [1:0]       Dbg_state
);

  // Handshake: a frame is accepted on a rising edge where Start=1 and Ready=1.
  // Ready is high only in IDLE, so Start is ignored (not queued) while Busy.

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [WIDTH-1:0] capture_q;
  logic             ready_q;
  logic             shift_en_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             core_shift;
  logic             core_msb;
  logic [WIDTH-1:0] core_data;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] len_eff;
  logic             unused_core_top;

  assign accept     = (state_q == ST_IDLE) && Start;
  assign core_shift = (state_q == ST_SHIFT);
  assign len_eff    = CNT_W'(eff_len(32'(Length), WIDTH));

  // Register value as it will be after the current shift edge.
  assign shifted         = {core_data[WIDTH-2:0], Shift_in};
  assign unused_core_top = core_data[WIDTH-1];

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i       (CLK),
    .clr_i       (Reset),
    .load_i      (accept),
    .load_data_i (Load_data),
    .shift_en_i  (core_shift),
    .shift_in_i  (Shift_in),
    .msb_o       (core_msb),
    .data_o      (core_data)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      capture_q  <= '0;
      ready_q    <= 1'b1;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q    <= ST_SHIFT;
            len_q      <= len_eff;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            shift_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q + ONE;
          // len_q is never 0 here, so the counter cannot wrap.
          if (cnt_q == len_q - ONE) begin
            capture_q  <= shifted;
            state_q    <= ST_DONE;
            shift_en_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
          shift_en_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign Ready        = ready_q;
  assign Shift_en     = shift_en_q;
  assign Shift_out    = shift_en_q & core_msb;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Capture_data = capture_q;
  assign Dbg_state    = state_q;

endmodule
